// File: rtl/dot_prod_pkg.sv
// Shared types and the saturating/wrapping accumulate helper for the
// dot-product engine.
package dot_prod_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic {MODE_AB, MODE_AA} mode_t;

  // Working width for the accumulate helper. Callers sign-extend operands
  // to this width, so any ACC_W up to SAT_W-1 is handled exactly.
  localparam int SAT_W = 128;

  // Adds prod to acc and range-checks the sum against a signed acc_w-bit
  // range. Returns {ovf, sum}. When saturate is set, an out-of-range sum is
  // clamped to the nearest bound; otherwise it is left for the caller to
  // truncate (two's-complement wrap).
  function automatic logic [SAT_W:0] sat_add(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] prod,
    input int                      acc_w,
    input logic                    saturate
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic                    ovf;
    sum = acc + prod;
    hi  = (SAT_W'(1) << (acc_w - 1)) - SAT_W'(1);
    lo  = ~hi;
    ovf = (sum > hi) || (sum < lo);
    if (saturate && ovf) sum = (sum > hi) ? hi : lo;
    return {ovf, sum};
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Single-port operand RAM: one write and one read share the address.
// The read address is registered, so data appears one cycle after the
// address is presented, and a write followed by a read of the same word
// returns the freshly written value.
module dp_ram #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;

  // Array write plus read-address capture; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (en) addr_q <= addr;
  end

  assign rdata = mem[addr_q];

endmodule

// File: rtl/dot_prod_pipe.sv
// Pipelined signed dot-product engine. One multiply-accumulate per cycle
// over two operand RAMs: RAM read -> product register -> accumulator.
// The host owns both RAMs whenever controlArr is high, which also cancels
// a running job.
module dot_prod_pipe
  import dot_prod_pkg::*;
#(
  parameter int DATA_W   = 27,
  parameter int ACC_W    = 64,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic              controlArr,
  input  logic [ADDR_W-1:0] init_i_t_a,
  input  logic [ADDR_W:0]   init_len,
  input  logic [ACC_W-1:0]  init_acc_t_a,
  input  logic              init_mode,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  input  logic [DATA_W-1:0] controlArrWData_a,
  output logic [DATA_W-1:0] controlArrRData_a,
  input  logic              controlArrWEnable_b,
  input  logic [ADDR_W-1:0] controlArrAddr_b,
  input  logic [DATA_W-1:0] controlArrWData_b,
  output logic [DATA_W-1:0] controlArrRData_b,
  output logic              busy,
  output logic              w_enable,
  output logic [ACC_W-1:0]  result,
  output logic              ovf,
  output logic              abort
);

  state_t state, state_nxt;
  mode_t  mode;

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   cnt;
  logic [1:0]        vld_pipe;   // [0]: RAM data valid, [1]: product valid

  logic start, cancel, issue;

  logic              a_en, b_en, a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_rdata, b_rdata;

  logic signed [DATA_W-1:0]   a_rd, b_rd, m_rd;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic [SAT_W:0]             sat_res;
  logic                       unused_sum_hi;

  assign start  = (state == IDLE) && r_enable && !controlArr;
  assign cancel = ((state == RUN) || (state == DRAIN)) && controlArr;
  assign issue  = (state == RUN);
  assign busy   = (state == RUN) || (state == DRAIN);

  // ---------------------------------------------------------------------
  // RAMs: host has priority on address/enable; the core only ever reads.
  // In A*A mode the B RAM read address is left untouched.
  // ---------------------------------------------------------------------
  assign a_en   = controlArr || issue;
  assign b_en   = controlArr || (issue && (mode == MODE_AB));
  assign a_we   = controlArr && controlArrWEnable_a;
  assign b_we   = controlArr && controlArrWEnable_b;
  assign a_addr = controlArr ? controlArrAddr_a : idx;
  assign b_addr = controlArr ? controlArrAddr_b : idx;

  dp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_a (
    .clk   (clk),
    .en    (a_en),
    .we    (a_we),
    .addr  (a_addr),
    .wdata (controlArrWData_a),
    .rdata (a_rdata)
  );

  dp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_b (
    .clk   (clk),
    .en    (b_en),
    .we    (b_we),
    .addr  (b_addr),
    .wdata (controlArrWData_b),
    .rdata (b_rdata)
  );

  assign controlArrRData_a = a_rdata;
  assign controlArrRData_b = b_rdata;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: RUN issues one address per cycle; DRAIN waits until the
  // last product sits in the product register (it is accumulated on the
  // edge into DONE); DONE publishes the result on its way back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (init_len == '0) ? DONE : RUN;
      RUN: begin
        if (cancel)                        state_nxt = IDLE;
        else if (cnt == (ADDR_W+1)'(1))    state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cancel)                        state_nxt = IDLE;
        else if (vld_pipe[1] && !vld_pipe[0]) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters and the walking index/remaining count. The index wraps
  // from DEPTH-1 to 0 so a job may straddle the end of the RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx  <= '0;
      cnt  <= '0;
      mode <= MODE_AB;
    end else if (start) begin
      idx  <= init_i_t_a;
      cnt  <= init_len;
      mode <= mode_t'(init_mode);
    end else if (issue) begin
      idx  <= (idx == ADDR_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  // Valid shift register tracking issued reads through the datapath;
  // flushed on cancel so nothing stale lands in the accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n || cancel) vld_pipe <= '0;
    else                  vld_pipe <= {vld_pipe[0], issue};
  end

  // ---------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------
  assign a_rd = a_rdata;
  assign b_rd = b_rdata;
  assign m_rd = (mode == MODE_AA) ? a_rd : b_rd;

  // Product register; full 2*DATA_W width holds even min*min exactly.
  always_ff @(posedge clk) begin
    if (vld_pipe[0]) prod <= (2*DATA_W)'(a_rd) * (2*DATA_W)'(m_rd);
  end

  assign sat_res       = sat_add(SAT_W'(acc), SAT_W'(prod), ACC_W, SATURATE != 0);
  assign unused_sum_hi = ^sat_res[SAT_W-1:ACC_W];

  // Accumulator: seeded at start, one step per valid product. In
  // saturating mode the clamped value is what later steps build on.
  always_ff @(posedge clk) begin
    if (!rst_n)                      acc <= '0;
    else if (start)                  acc <= init_acc_t_a;
    else if (vld_pipe[1] && !cancel) acc <= sat_res[ACC_W-1:0];
  end

  // Sticky overflow for the current job, cleared when a job is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n)                                       ovf <= 1'b0;
    else if (start)                                   ovf <= 1'b0;
    else if (vld_pipe[1] && !cancel && sat_res[SAT_W]) ovf <= 1'b1;
  end

  // Completion/abort pulses and the held result. The result updates on the
  // same edge that raises w_enable; an aborted job leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_enable <= 1'b0;
      abort    <= 1'b0;
      result   <= '0;
    end else begin
      w_enable <= (state == DONE);
      abort    <= cancel;
      if (state == DONE) result <= acc;
    end
  end

endmodule

// File: tb/tb_dot_prod_pipe.sv
// Directed bench for dot_prod_pipe. Two instances run in lockstep, one
// wrapping and one saturating; the stimulus pushes expected completions
// into a queue and a negedge monitor pops and compares each pulse.
module tb_dot_prod_pipe;
  localparam int DATA_W = 27;
  localparam int ACC_W  = 64;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r_enable = 1'b0, controlArr = 1'b0, init_mode = 1'b0;
  logic [ADDR_W-1:0] init_i = '0;
  logic [ADDR_W:0]   init_len = '0;
  logic [ACC_W-1:0]  init_acc = '0;
  logic              we_a = 1'b0, we_b = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wd_a = '0, wd_b = '0;

  logic [DATA_W-1:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic busy0, w0, ovf0, ab0, busy1, w1, ovf1, ab1;
  logic [ACC_W-1:0] res0, res1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dot_prod_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .controlArr(controlArr),
    .init_i_t_a(init_i), .init_len(init_len), .init_acc_t_a(init_acc), .init_mode(init_mode),
    .controlArrWEnable_a(we_a), .controlArrAddr_a(addr_a), .controlArrWData_a(wd_a),
    .controlArrRData_a(rd_a0),
    .controlArrWEnable_b(we_b), .controlArrAddr_b(addr_b), .controlArrWData_b(wd_b),
    .controlArrRData_b(rd_b0),
    .busy(busy0), .w_enable(w0), .result(res0), .ovf(ovf0), .abort(ab0)
  );

  dot_prod_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .controlArr(controlArr),
    .init_i_t_a(init_i), .init_len(init_len), .init_acc_t_a(init_acc), .init_mode(init_mode),
    .controlArrWEnable_a(we_a), .controlArrAddr_a(addr_a), .controlArrWData_a(wd_a),
    .controlArrRData_a(rd_a1),
    .controlArrWEnable_b(we_b), .controlArrAddr_b(addr_b), .controlArrWData_b(wd_b),
    .controlArrRData_b(rd_b1),
    .busy(busy1), .w_enable(w1), .result(res1), .ovf(ovf1), .abort(ab1)
  );

  typedef struct {
    bit              is_abort;
    int              due;
    logic [ACC_W-1:0] r0;
    bit              o0;
    logic [ACC_W-1:0] r1;
    bit              o1;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every completion or abort pulse must match the queue head.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && (w0 || ab0 || w1 || ab1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {60'd0, w0, ab0, w1, ab1}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_pulse",  {62'd0, w0, w1},  e.is_abort ? 64'd0 : 64'd3);
        chk("abort_pulse", {62'd0, ab0, ab1}, e.is_abort ? 64'd3 : 64'd0);
        chk("pulse_cycle", 64'(cyc), 64'(e.due));
        chk("result_wrap", res0, e.r0);
        chk("ovf_wrap",    {63'd0, ovf0}, {63'd0, e.o0});
        chk("result_sat",  res1, e.r1);
        chk("ovf_sat",     {63'd0, ovf1}, {63'd0, e.o1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int a, input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb);
    controlArr = 1'b1;
    we_a = 1'b1; we_b = 1'b1;
    addr_a = ADDR_W'(a); addr_b = ADDR_W'(a);
    wd_a = va; wd_b = vb;
    tick();
    we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic start_job(input int i, input int len, input logic [ACC_W-1:0] acc,
                           input bit mode, output int e0);
    controlArr = 1'b0;
    init_i = ADDR_W'(i); init_len = (ADDR_W+1)'(len);
    init_acc = acc; init_mode = mode;
    r_enable = 1'b1;
    e0 = cyc + 1;
    tick();
    r_enable = 1'b0;
  endtask

  task automatic push(input bit ab, input int due, input logic [ACC_W-1:0] r0, input bit o0,
                      input logic [ACC_W-1:0] r1, input bit o1);
    exp_t x;
    x.is_abort = ab; x.due = due; x.r0 = r0; x.o0 = o0; x.r1 = r1; x.o1 = o1;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) tick();
    chk("pending_events", 64'(sb.size()), 64'd0);
    tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int  e0;
    bit  seen;
    tick(); tick(); tick();
    rst_n = 1'b1;
    chk("rst_busy",   {62'd0, busy0, busy1}, 64'd0);
    chk("rst_result", res0 | res1, 64'd0);
    chk("rst_flags",  {60'd0, ovf0, ovf1, w0, ab0}, 64'd0);

    // 1: A[k]=k+1, B[k]=2 -> 2*36
    for (int k = 0; k < 8; k++) host_wr(k, DATA_W'(k + 1), DATA_W'(2));
    addr_a = 10'd3; tick();
    chk("host_rd_a3", 64'(rd_a0), 64'd4);
    we_b = 1'b1; addr_b = 10'd20; wd_b = DATA_W'(77); tick(); we_b = 1'b0;
    chk("host_rdw_b20", 64'(rd_b0), 64'd77);
    start_job(0, 8, 64'd0, 1'b0, e0);
    push(0, e0 + 11, 64'd72, 0, 64'd72, 0);
    wait_idle(40);

    // 2: index wrap 1022,1023,0,1; guard word at 1021
    host_wr(1021, DATA_W'(5), DATA_W'(5));
    host_wr(1022, DATA_W'(1), DATA_W'(1));
    host_wr(1023, DATA_W'(1), DATA_W'(1));
    host_wr(0,    DATA_W'(1), DATA_W'(1));
    host_wr(1,    DATA_W'(1), DATA_W'(1));
    start_job(1022, 4, -64'sd10, 1'b0, e0);
    push(0, e0 + 7, -64'sd6, 0, -64'sd6, 0);
    wait_idle(40);

    // 3: zero-length job
    start_job(5, 0, 64'h1234, 1'b0, e0);
    push(0, e0 + 1, 64'h1234, 0, 64'h1234, 0);
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      seen = seen | busy0 | busy1;
      tick();
    end
    chk("len0_busy", {63'd0, seen}, 64'd0);
    wait_idle(20);

    // 5a: A*A mode, B holds junk
    host_wr(10, DATA_W'(3), DATA_W'(100));
    host_wr(11, DATA_W'(-4), DATA_W'(7));
    start_job(10, 2, 64'd0, 1'b1, e0);
    push(0, e0 + 5, 64'd25, 0, 64'd25, 0);
    wait_idle(40);

    // 5b: host grabs the RAMs during RUN cycle 2 of a 16-long job
    start_job(0, 16, 64'd0, 1'b0, e0);
    tick(); tick();
    controlArr = 1'b1;
    push(1, e0 + 3, 64'd25, 0, 64'd25, 0);
    tick(); tick();
    controlArr = 1'b0;
    wait_idle(40);
    chk("abort_busy", {62'd0, busy0, busy1}, 64'd0);
    for (int n = 0; n < 20; n++) tick();

    // 6a: start strobe while busy is ignored; A[2..7]=3..8, B=2
    start_job(2, 6, 64'd0, 1'b0, e0);
    push(0, e0 + 9, 64'd66, 0, 64'd66, 0);
    tick(); tick(); tick();
    chk("busy_run", {62'd0, busy0, busy1}, 64'd3);
    init_len = '0; init_acc = 64'd1000; r_enable = 1'b1;
    tick();
    r_enable = 1'b0;
    wait_idle(40);

    // 6b: reset during DRAIN
    start_job(2, 6, 64'd0, 1'b0, e0);
    for (int n = 0; n < 6; n++) tick();
    chk("busy_drain", {62'd0, busy0, busy1}, 64'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy",   {62'd0, busy0, busy1}, 64'd0);
    chk("midrst_result", res0 | res1, 64'd0);
    chk("midrst_flags",  {60'd0, ovf0, ovf1, w0, ab0}, 64'd0);
    for (int n = 0; n < 10; n++) tick();

    // 4: 1024 products of 2^52 from 2^63-2^52
    for (int k = 0; k < DEPTH; k++) host_wr(k, 27'h4000000, 27'h4000000);
    start_job(0, 1024, 64'h7FF0_0000_0000_0000, 1'b0, e0);
    push(0, e0 + 1027, 64'hBFF0_0000_0000_0000, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    wait_idle(1200);

    // 7: next job clears the sticky overflow
    start_job(0, 0, 64'd5, 1'b0, e0);
    push(0, e0 + 1, 64'd5, 0, 64'd5, 0);
    wait_idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
